// File: rtl/beta_div16_pkg.sv
// beta_div_pkg: shared types and constants for the Beta ALU sequential divider.
//   div_state_t : divider FSM states
//   DIV_W       : datapath width
//   DIV_STEPS   : value of the 4-bit step counter on the last CALC step
//   DIV_DZ_Q    : quotient reported on divide-by-zero
package beta_div_pkg;

    localparam int unsigned DIV_W     = 16;
    localparam logic [3:0]  DIV_STEPS = 4'd15;
    localparam logic [15:0] DIV_DZ_Q  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_t;

endpackage

// File: rtl/cla_add16.sv
// cla_add16: 16-bit carry-lookahead adder built from four 4-bit groups.
// Ports:
//   a, b : addends
//   ci   : carry in
//   s    : sum
//   g, p : group generate / propagate; carry out = g | (p & ci)
module cla_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        g,
    output logic        p
);

    logic [15:0] gi;
    logic [15:0] pi;
    logic [15:0] c;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [3:0]  gc;

    // Carries into the four bits of one group, given that group's carry in.
    function automatic logic [3:0] carries4(input logic [3:0] g4,
                                            input logic [3:0] p4,
                                            input logic       cin);
        logic [3:0] cc;
        cc[0] = cin;
        cc[1] = g4[0] | (p4[0] & cin);
        cc[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
        cc[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
              | (p4[2] & p4[1] & p4[0] & cin);
        return cc;
    endfunction

    always_comb begin
        gi = a & b;
        pi = a ^ b;
        for (int unsigned k = 0; k < 4; k++) begin
            bg[k] = gi[4*k+3] | (pi[4*k+3] & gi[4*k+2])
                  | (pi[4*k+3] & pi[4*k+2] & gi[4*k+1])
                  | (pi[4*k+3] & pi[4*k+2] & pi[4*k+1] & gi[4*k]);
            bp[k] = &pi[4*k +: 4];
        end
        gc = carries4(bg, bp, ci);
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k +: 4] = carries4(gi[4*k +: 4], pi[4*k +: 4], gc[k]);
        end
        s = pi ^ c;
        g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
          | (bp[3] & bp[2] & bp[1] & bg[0]);
        p = &bp;
    end

endmodule

// File: rtl/beta_div16.sv
// beta_div16: sequential 16-bit restoring divider, one step per clock.
// Optional signed support is compiled in with `define BETA_DIV16_SIGNED_EN.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle, latches a and b
//   sgn        : signed operation (only with BETA_DIV16_SIGNED_EN)
//   a, b       : dividend, divisor
//   busy       : high while not idle
//   done       : one-cycle pulse, results valid
//   dz         : divide-by-zero flag, held until next start
//   q, r       : quotient and remainder, held until next start
module beta_div16
    import beta_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [DIV_W-1:0] dvs;
    logic [3:0]       cnt;
    logic [DIV_W-1:0] a_mag;
    logic [DIV_W-1:0] b_mag;
    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] trial;
    logic             cla_g;
    logic             cla_p;
    logic             accept;

`ifdef BETA_DIV16_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        a_mag = (sgn && a[DIV_W-1]) ? -a : a;
        b_mag = (sgn && b[DIV_W-1]) ? -b : b;
    end
`else
    logic sgn_unused;
    assign sgn_unused = sgn;

    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // q doubles as the dividend shift register: its MSB feeds the remainder
    // while quotient bits enter at the LSB.
    assign shifted = {r[DIV_W-2:0], q[DIV_W-1]};

    cla_add16 u_cla (
        .a  (shifted),
        .b  (~dvs),
        .ci (1'b1),
        .s  (trial),
        .g  (cla_g),
        .p  (cla_p)
    );

    // r[15] is the bit shifted out of the 16-bit window; when set the true
    // partial remainder is >= 2^16 and always exceeds the divisor.
    assign accept = r[DIV_W-1] | cla_g | (cla_p & 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (b == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == DIV_STEPS) begin
`ifdef BETA_DIV16_SIGNED_EN
                    state_nxt = ST_FIX;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
            dvs <= '0;
            cnt <= '0;
`ifdef BETA_DIV16_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvs <= b_mag;
                        cnt <= '0;
`ifdef BETA_DIV16_SIGNED_EN
                        neg_q <= sgn & (a[DIV_W-1] ^ b[DIV_W-1]);
                        neg_r <= sgn & a[DIV_W-1];
`endif
                        if (b == '0) begin
                            dz <= 1'b1;
                            q  <= DIV_DZ_Q;
                            r  <= a;
                        end else begin
                            dz <= 1'b0;
                            q  <= a_mag;
                            r  <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r   <= accept ? trial : shifted;
                    q   <= {q[DIV_W-2:0], accept};
                    cnt <= cnt + 4'd1;
                end
`ifdef BETA_DIV16_SIGNED_EN
                ST_FIX: begin
                    if (neg_q) q <= -q;
                    if (neg_r) r <= -r;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beta_div16.sv
// tb_beta_div16: self-checking bench for beta_div16 (table vectors, random
// operands against an arithmetic reference, and handshake corner cases).
module tb_beta_div16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        dz;
    logic [15:0] q;
    logic [15:0] r;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BETA_DIV16_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          sgn;
        logic [15:0] q;
        logic [15:0] r;
        bit          dz;
    } vec_t;

    vec_t vt[$];

    beta_div16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .q     (q),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input bit ms,
                         output logic [15:0] mq, output logic [15:0] mr,
                         output bit mdz, output int mlat);
        int sa, sb, qq, rr;
        mdz  = 1'b0;
        mlat = (SIGNED_BUILD && ms) ? 17 : 16;
        if (mb == 16'd0) begin
            mdz = 1'b1; mq = 16'hFFFF; mr = ma; mlat = 0;
        end else if (SIGNED_BUILD && ms) begin
            sa = $signed(ma);
            sb = $signed(mb);
            qq = sa / sb;
            rr = sa % sb;
            mq = qq[15:0];
            mr = rr[15:0];
        end else begin
            mq = ma / mb;
            mr = ma % mb;
        end
    endtask

    // Launch one operation; lat = index of the edge after which done is seen
    // (edge 0 samples start), -1 on timeout.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input bit ts,
                         output logic [15:0] oq, output logic [15:0] orr, output bit odz,
                         output int lat, output int busy_cnt, output bit one_pulse);
        @(negedge clk);
        a = ta; b = tb; sgn = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_cnt = 0;
        oq = '0; orr = '0; odz = 1'b0; one_pulse = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k; oq = q; orr = r; odz = dz;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            one_pulse = !done && !busy;
        end
    endtask

    task automatic run_check(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input bit ts, input logic [15:0] eq, input logic [15:0] er,
                             input bit edz, input int elat);
        logic [15:0] gq, gr;
        bit gdz, pulse;
        int lat, bc;
        do_op(ta, tb, ts, gq, gr, gdz, lat, bc, pulse);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " q"}, gq, eq);
        chk({tag, " r"}, gr, er);
        chk({tag, " dz"}, gdz, edz);
        chk({tag, " done width"}, pulse, 1);
    endtask

    initial begin
        logic [15:0] eq, er, gq, gr, ra, rb;
        bit edz, gdz, pulse, rs;
        int elat, lat, bc, seen;

        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #23;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dz",   dz,   0);
        chk("reset q",    q,    0);
        chk("reset r",    r,    0);
        @(negedge clk); rst_n = 1'b1;

        vt.push_back('{16'd100,   16'd7,     1'b0, 16'd14,   16'd2,    1'b0});
        vt.push_back('{16'hFFFF,  16'd1,     1'b0, 16'hFFFF, 16'd0,    1'b0});
        vt.push_back('{16'd5,     16'hFFFF,  1'b0, 16'd0,    16'd5,    1'b0});
        vt.push_back('{16'd1234,  16'd0,     1'b0, 16'hFFFF, 16'd1234, 1'b1});
        vt.push_back('{16'hFFFF,  16'hFFFF,  1'b0, 16'd1,    16'd0,    1'b0});
        vt.push_back('{16'd6,     16'd7,     1'b0, 16'd0,    16'd6,    1'b0});
`ifdef BETA_DIV16_SIGNED_EN
        vt.push_back('{16'hFFF9,  16'd2,     1'b1, 16'hFFFD, 16'hFFFF, 1'b0});
        vt.push_back('{16'd7,     16'hFFFE,  1'b1, 16'hFFFD, 16'd1,    1'b0});
        vt.push_back('{16'h8000,  16'hFFFF,  1'b1, 16'h8000, 16'd0,    1'b0});
        vt.push_back('{16'hFFF9,  16'd0,     1'b1, 16'hFFFF, 16'hFFF9, 1'b1});
`else
        vt.push_back('{16'hFFF9,  16'd2,     1'b1, 16'h7FFC, 16'd1,    1'b0});
`endif

        // Busy window for the reference 100/7 case.
        do_op(16'd100, 16'd7, 1'b0, gq, gr, gdz, lat, bc, pulse);
        chk("100/7 busy cycles", bc, 17);

        foreach (vt[i]) begin
            elat = (vt[i].dz) ? 0 : ((SIGNED_BUILD && vt[i].sgn) ? 17 : 16);
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sgn,
                      vt[i].q, vt[i].r, vt[i].dz, elat);
        end

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case (i % 3)
                0:       rb = 16'($urandom_range(1, 15));
                1:       rb = $urandom;
                default: rb = (i % 10 == 2) ? 16'd0 : 16'($urandom_range(0, 300));
            endcase
            rs = $urandom_range(0, 1);
            model(ra, rb, rs, eq, er, edz, elat);
            run_check($sformatf("rnd%0d %0h/%0h s%0d", i, ra, rb, rs), ra, rb, rs, eq, er, edz, elat);
        end

        // start while busy must neither abort nor queue.
        @(negedge clk);
        a = 16'd100; b = 16'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin a = 16'd9; b = 16'd2; start = 1'b1; end
            if (k == 6) start = 1'b0;
            if (done) begin lat = k; gq = q; gr = r; break; end
            @(posedge clk); #1;
        end
        chk("busy-start latency", lat, 16);
        chk("busy-start q", gq, 14);
        chk("busy-start r", gr, 2);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("busy-start not queued", seen, 0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a = 16'd100; b = 16'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset dz",   dz,   0);
        chk("midreset q",    q,    0);
        chk("midreset r",    r,    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("midreset no done", seen, 0);
        run_check("after reset 100/7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
